// File: rtl/core_alu_mc.sv
`timescale 1ns/1ps
// core_alu_mc_pkg
//   Shared types for the multi-cycle execute-stage ALU: the core
//   configuration record and the one-hot operation encoding.
package core_alu_mc_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } config_t;

    localparam config_t DEFAULT_CONF = '{XLEN: 32};

    typedef logic [8:0] alu_op_t;

    localparam alu_op_t OP_ADD   = 9'h001;
    localparam alu_op_t OP_SUB   = 9'h002;
    localparam alu_op_t OP_OR    = 9'h004;
    localparam alu_op_t OP_SRL   = 9'h008;
    localparam alu_op_t OP_SLTU  = 9'h010;
    localparam alu_op_t OP_MUL   = 9'h020;
    localparam alu_op_t OP_MULHU = 9'h040;
    localparam alu_op_t OP_DIVU  = 9'h080;
    localparam alu_op_t OP_REMU  = 9'h100;

endpackage

// core_alu_mc
//   Multi-cycle integer ALU for the execute stage. Short ops (ADD, SUB, OR,
//   SRL, SLTU) produce a registered result one cycle after accept; MUL, MULHU,
//   DIVU and REMU run an iterative radix-2 datapath for XLEN cycles.
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   flush             synchronous abort of any in-flight or pending op
//   in_valid/in_ready operand handshake (ready only while idle)
//   src_a, src_b      operands, latched at accept
//   alu_op            one-hot operation select
//   out_valid/out_ready result handshake
//   alu_res           registered result
//   alu_zero          alu_res == 0, registered with alu_res
//   alu_illegal       alu_op was not exactly one-hot
module core_alu_mc
    import core_alu_mc_pkg::*;
#(
    parameter config_t CONF    = DEFAULT_CONF,
    parameter int      SHAMT_W = $clog2(CONF.XLEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CONF.XLEN-1:0] src_a,
    input  logic [CONF.XLEN-1:0] src_b,
    input  alu_op_t              alu_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CONF.XLEN-1:0] alu_res,
    output logic                 alu_zero,
    output logic                 alu_illegal
);

    localparam int XLEN  = int'(CONF.XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {L_MUL, L_MULHU, L_DIVU, L_REMU} long_sel_t;

    state_t          state;
    state_t          state_nx;
    long_sel_t       long_sel;
    long_sel_t       sel_nx;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] op_b;
    logic [CNT_W-1:0] iter_cnt;

    logic            accept;
    logic            op_legal;
    logic            op_long;
    logic            last_iter;
    logic            is_div;
    logic [XLEN-1:0] short_res;
    logic [XLEN-1:0] long_res;

    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_nx;
    logic [XLEN-1:0] mul_lo_nx;
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_hi_nx;
    logic [XLEN-1:0] div_lo_nx;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    // flush wins over a same-cycle request, so nothing is accepted
    assign accept    = in_valid & in_ready & ~flush;
    assign op_legal  = (alu_op != '0) && ((alu_op & (alu_op - 9'd1)) == '0);
    assign op_long   = op_legal &&
                       ((alu_op & (OP_MUL | OP_MULHU | OP_DIVU | OP_REMU)) != '0);
    assign last_iter = (iter_cnt == CNT_W'(XLEN - 1));
    assign is_div    = (long_sel == L_DIVU) || (long_sel == L_REMU);

    // Single-cycle results; any non-one-hot code falls to zero
    always_comb begin
        short_res = '0;
        case (alu_op)
            OP_ADD:  short_res = src_a + src_b;
            OP_SUB:  short_res = src_a - src_b;
            OP_OR:   short_res = src_a | src_b;
            OP_SRL:  short_res = src_a >> src_b[SHAMT_W-1:0];
            OP_SLTU: short_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default: short_res = '0;
        endcase
    end

    always_comb begin
        sel_nx = L_REMU;
        if (alu_op == OP_MUL)
            sel_nx = L_MUL;
        else if (alu_op == OP_MULHU)
            sel_nx = L_MULHU;
        else if (alu_op == OP_DIVU)
            sel_nx = L_DIVU;
    end

    // Shift-add step: {acc_hi, acc_lo} holds partial product and the
    // remaining multiplier bits; multiplicand sits in op_b.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
        mul_hi_nx = mul_sum[XLEN:1];
        mul_lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
    end

    // Restoring division step: acc_hi is the remainder, acc_lo shifts the
    // dividend out and quotient bits in. A zero divisor naturally yields an
    // all-ones quotient and the dividend as remainder.
    always_comb begin
        rem_sh    = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = (rem_sh >= {1'b0, op_b});
        div_hi_nx = div_ge ? (rem_sh[XLEN-1:0] - op_b) : rem_sh[XLEN-1:0];
        div_lo_nx = {acc_lo[XLEN-2:0], div_ge};
    end

    // The final step's value goes straight to the result register
    always_comb begin
        long_res = '0;
        case (long_sel)
            L_MUL:   long_res = mul_lo_nx;
            L_MULHU: long_res = mul_hi_nx;
            L_DIVU:  long_res = div_lo_nx;
            L_REMU:  long_res = div_hi_nx;
            default: long_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = op_long ? S_BUSY : S_DONE;
            S_BUSY:  if (last_iter) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush)
            state_nx = S_IDLE;
    end

    // Result registers only change on completion, so a flushed or reset
    // long op never exposes a partial value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi      <= '0;
            acc_lo      <= '0;
            op_b        <= '0;
            iter_cnt    <= '0;
            long_sel    <= L_MUL;
            alu_res     <= '0;
            alu_zero    <= 1'b0;
            alu_illegal <= 1'b0;
        end else if (accept) begin
            iter_cnt <= '0;
            acc_hi   <= '0;
            if (op_long) begin
                long_sel <= sel_nx;
                if (alu_op == OP_DIVU || alu_op == OP_REMU) begin
                    acc_lo <= src_a;
                    op_b   <= src_b;
                end else begin
                    acc_lo <= src_b;
                    op_b   <= src_a;
                end
            end else begin
                alu_res     <= short_res;
                alu_zero    <= (short_res == '0);
                alu_illegal <= ~op_legal;
            end
        end else if (state == S_BUSY && !flush) begin
            iter_cnt <= iter_cnt + CNT_W'(1);
            acc_hi   <= is_div ? div_hi_nx : mul_hi_nx;
            acc_lo   <= is_div ? div_lo_nx : mul_lo_nx;
            if (last_iter) begin
                alu_res     <= long_res;
                alu_zero    <= (long_res == '0);
                alu_illegal <= 1'b0;
            end
        end
    end

endmodule
